// File: rtl/hex_seg_driver.sv
// ============================================================================
// hex_seg_driver
// ----------------------------------------------------------------------------
// Sits after a 7-bit hex-display PIO. It takes the raw segment pattern
// (1 = lit) and drives one HEX digit pin group. On top of the pattern it adds
// PWM brightness, blinking, pattern freeze and output polarity. A Nios II
// configures it through a small 4-word Avalon-MM slave. The slave has zero
// wait states, and readdata is combinational from address.
//
// Optional feature (compile-time macro HEX_DRV_FADE_EN):
//   When defined, the effective duty level is a register. After every pattern
//   change it restarts from 0 and ramps up by one step per PWM frame towards
//   BRIGHT. When undefined, the effective duty level is simply BRIGHT.
//
// Parameters:
//   TICK_DIV        clk cycles per PWM step (>=1); frame = 256*TICK_DIV cycles
//   SEG_ACTIVE_LOW  1: hex_out inverted (segment on = 0); 0: active-high pins
//
// Ports:
//   clk         in   1   system clock
//   reset_n     in   1   asynchronous, active-low reset
//   seg_in      in   7   segment pattern from PIO, bit6..0 = g..a, 1 = lit
//   address     in   2   register select (0 CTRL, 1 BRIGHT, 2 BLINK, 3 STATUS)
//   chipselect  in   1   slave select
//   write_n     in   1   active-low write strobe
//   writedata   in   32  write data
//   readdata    out  32  read data, combinational from address, unused bits 0
//   hex_out     out  7   to HEX pins, registered
// ============================================================================
module hex_seg_driver #(
    parameter int TICK_DIV       = 195,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  seg_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  hex_out
);

    localparam int             PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [6:0]     OFF_PAT  = {7{SEG_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [2:0] ctrl_q,   ctrl_d;     // [0] enable [1] blink_en [2] freeze
    logic [7:0] bright_q, bright_d;
    logic [7:0] blink_q,  blink_d;
    logic       changed_q, changed_d;

    // ------------------------------------------------------------------
    // Timing chain and display state
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       frm_cnt_q, frm_cnt_d;
    logic             phase_q,   phase_d;
    logic [6:0]       seg_lat_q, seg_lat_d;
    logic [6:0]       hex_q,     hex_d;

    logic       wr_en;
    logic       wr_ctrl, wr_bright, wr_blink, wr_status;
    logic       step, frame;
    logic       chg_set;
    logic       lit, visible;
    logic       fading;
    logic [7:0] eff_bright;

    // Only the low byte of writedata ever reaches a register.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:8];

    assign wr_en     = chipselect & ~write_n;
    assign wr_ctrl   = wr_en && (address == 2'd0);
    assign wr_bright = wr_en && (address == 2'd1);
    assign wr_blink  = wr_en && (address == 2'd2);
    assign wr_status = wr_en && (address == 2'd3);

    assign step  = (pre_cnt_q == PRE_LAST);
    assign frame = step && (pwm_cnt_q == 8'hFF);

    // A new pattern is taken this cycle and it differs from the held one.
    assign chg_set = ~ctrl_q[2] && (seg_in != seg_lat_q);

`ifdef HEX_DRV_FADE_EN
    logic [7:0] eff_bright_q, eff_bright_d;

    // Priority: a pattern change restarts the ramp, then a lowered BRIGHT
    // snaps down at once, and otherwise the level climbs one step per frame.
    always_comb begin
        eff_bright_d = eff_bright_q;
        if (chg_set) begin
            eff_bright_d = 8'h00;
        end else if (bright_q < eff_bright_q) begin
            eff_bright_d = bright_q;
        end else if (frame && (eff_bright_q != bright_q)) begin
            eff_bright_d = eff_bright_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eff_bright_q <= 8'hFF;
        end else begin
            eff_bright_q <= eff_bright_d;
        end
    end

    assign eff_bright = eff_bright_q;
    assign fading     = (eff_bright_q != bright_q);
`else
    assign eff_bright = bright_q;
    assign fading     = 1'b0;
`endif

    // Full scale must be lit on every PWM count. A plain compare would leave
    // pwm_cnt==255 dark.
    assign lit     = (eff_bright == 8'hFF) || (pwm_cnt_q < eff_bright);
    assign visible = ctrl_q[0] && lit && !(ctrl_q[1] && phase_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d    = ctrl_q;
        bright_d  = bright_q;
        blink_d   = blink_q;
        changed_d = changed_q;
        pre_cnt_d = pre_cnt_q;
        pwm_cnt_d = pwm_cnt_q;
        frm_cnt_d = frm_cnt_q;
        phase_d   = phase_q;
        seg_lat_d = seg_lat_q;

        if (wr_ctrl)   ctrl_d   = writedata[2:0];
        if (wr_bright) bright_d = writedata[7:0];
        if (wr_blink)  blink_d  = writedata[7:0];

        // If a set and a clear happen in the same cycle, the set wins,
        // so a change is never lost.
        if (chg_set) begin
            changed_d = 1'b1;
        end else if (wr_status && writedata[1]) begin
            changed_d = 1'b0;
        end

        pre_cnt_d = step ? '0 : pre_cnt_q + PRE_W'(1);
        if (step) pwm_cnt_d = pwm_cnt_q + 8'd1;

        // Turning blink off through CTRL re-arms it from a visible phase.
        // A BLINK value of 0 freezes the phase where it is.
        if (wr_ctrl && !writedata[1]) begin
            phase_d   = 1'b0;
            frm_cnt_d = 8'h00;
        end else if (ctrl_q[1] && frame && (blink_q != 8'h00)) begin
            if (frm_cnt_q == blink_q - 8'd1) begin
                phase_d   = ~phase_q;
                frm_cnt_d = 8'h00;
            end else begin
                frm_cnt_d = frm_cnt_q + 8'd1;
            end
        end

        if (!ctrl_q[2]) seg_lat_d = seg_in;
    end

    // Each segment is gated by visibility, then polarity is applied.
    for (genvar gi = 0; gi < 7; gi++) begin : g_seg
        assign hex_d[gi] = (visible & seg_lat_q[gi]) ^ OFF_PAT[gi];
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= 3'b001;
            bright_q  <= 8'hFF;
            blink_q   <= 8'd250;
            changed_q <= 1'b0;
            pre_cnt_q <= '0;
            pwm_cnt_q <= 8'h00;
            frm_cnt_q <= 8'h00;
            phase_q   <= 1'b0;
            seg_lat_q <= 7'h00;
            hex_q     <= OFF_PAT;
        end else begin
            ctrl_q    <= ctrl_d;
            bright_q  <= bright_d;
            blink_q   <= blink_d;
            changed_q <= changed_d;
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            frm_cnt_q <= frm_cnt_d;
            phase_q   <= phase_d;
            seg_lat_q <= seg_lat_d;
            hex_q     <= hex_d;
        end
    end

    assign hex_out = hex_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = 32'h0;
        case (address)
            2'd0:    readdata = {29'h0, ctrl_q};
            2'd1:    readdata = {24'h0, bright_q};
            2'd2:    readdata = {24'h0, blink_q};
            default: readdata = {29'h0, fading, changed_q, phase_q};
        endcase
    end

endmodule

// File: tb/tb_hex_seg_driver.sv
// ============================================================================
// tb_hex_seg_driver
// ----------------------------------------------------------------------------
// Self-checking bench for hex_seg_driver, built with TICK_DIV=2 and
// SEG_ACTIVE_LOW=1, so one PWM frame is 512 clk.
// ============================================================================
module tb_hex_seg_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [6:0]  hex_out;

    hex_seg_driver #(
        .TICK_DIV       (2),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .seg_in     (seg_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hex_out    (hex_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        logic [2:0] ctrl;
        logic [6:0] seg;
        logic [6:0] exp_hex;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic sb_check(input string name, input logic [6:0] act);
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %h expected <scoreboard empty>", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, {25'h0, act}, {25'h0, e});
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Counts cycles showing the given pattern, plus cycles that show neither
    // that pattern nor the all-off code.
    task automatic count_lit(input logic [6:0] pat, input int n, output int lit, output int other);
        lit   = 0;
        other = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (hex_out == (~pat & 7'h7F)) lit++;
            else if (hex_out != 7'h7F) other++;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int lit, other, vis, toggles, errs;
        logic ph, ph_prev;

        vecs[0] = '{3'b001, 7'h3F, 7'h40};
        vecs[1] = '{3'b001, 7'h06, 7'h79};
        vecs[2] = '{3'b000, 7'h5B, 7'h7F};
        vecs[3] = '{3'b001, 7'h7F, 7'h00};
        vecs[4] = '{3'b001, 7'h00, 7'h7F};
        vecs[5] = '{3'b011, 7'h4F, 7'h30};
        vecs[6] = '{3'b001, 7'h66, 7'h19};
        vecs[7] = '{3'b000, 7'h00, 7'h7F};

        reset_n    = 1'b0;
        seg_in     = 7'h3F;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        // ---- 1: reset state and first-pattern latency ----
        repeat (3) @(negedge clk);
        check("rst_hex", {25'h0, hex_out}, 32'h7F);
        bus_read(2'd0, rd); check("rst_ctrl",   rd, 32'h1);
        bus_read(2'd1, rd); check("rst_bright", rd, 32'hFF);
        bus_read(2'd2, rd); check("rst_blink",  rd, 32'd250);
        bus_read(2'd3, rd); check("rst_status", rd, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_1clk", {25'h0, hex_out}, 32'h7F);
        exp_q.push_back(7'h40);
        @(negedge clk);
        sb_check("post_rst_2clk", hex_out);
        repeat (5) @(negedge clk);
        check("post_rst_steady", {25'h0, hex_out}, 32'h40);
        bus_read(2'd3, rd); check("status_changed_after_rst", rd, 32'h2);

        // ---- table vectors: CTRL + pattern -> hex_out ----
        for (int i = 0; i < 8; i++) begin
            bus_write(2'd0, {29'h0, vecs[i].ctrl});
            seg_in = vecs[i].seg;
            exp_q.push_back(vecs[i].exp_hex);
            repeat (2) @(negedge clk);
            sb_check($sformatf("vec%0d", i), hex_out);
        end

        // ---- 2: PWM duty ----
        bus_write(2'd0, 32'h1);
        seg_in = 7'h3F;
        bus_write(2'd1, 32'h40);
        repeat (4) @(negedge clk);
        count_lit(7'h3F, 512, lit, other);
        check("pwm_40_lit", lit, 128);
        check("pwm_40_other", other, 0);
        bus_write(2'd1, 32'h00);
        repeat (4) @(negedge clk);
        count_lit(7'h3F, 512, lit, other);
        check("pwm_00_lit", lit, 0);
        bus_write(2'd1, 32'h04);
        repeat (4) @(negedge clk);
        count_lit(7'h3F, 512, lit, other);
        check("pwm_04_lit", lit, 8);
        bus_write(2'd1, 32'hFF);
        repeat (4) @(negedge clk);
        count_lit(7'h3F, 512, lit, other);
        check("pwm_FF_lit", lit, 512);

        // ---- 3: blink, BLINK=2 -> 1024 visible / 1024 dark ----
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h3);
        repeat (2100) @(negedge clk);
        vis = 0; toggles = 0; errs = 0;
        bus_read(2'd3, rd);
        ph_prev = rd[0];
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            bus_read(2'd3, rd);
            ph = rd[0];
            if (hex_out != (ph_prev ? 7'h7F : 7'h40)) errs++;
            if (hex_out == 7'h40) vis++;
            if (ph != ph_prev) toggles++;
            ph_prev = ph;
        end
        check("blink_track_errs", errs, 0);
        check("blink_visible", vis, 1024);
        check("blink_toggles", toggles, 2);
        bus_write(2'd0, 32'h1);
        bus_read(2'd3, rd); check("blink_off_phase0", {31'h0, rd[0]}, 32'h0);

        // BLINK=0 holds the phase, so the digit is visible throughout.
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h3);
        count_lit(7'h3F, 2048, lit, other);
        check("blink0_visible", lit, 2048);
        bus_write(2'd0, 32'h1);

        // ---- 4: freeze and sticky changed ----
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rd); check("changed_cleared", {31'h0, rd[1]}, 32'h0);
        bus_write(2'd0, 32'h5);
        seg_in = 7'h06;
        repeat (4) @(negedge clk);
        check("freeze_hold_hex", {25'h0, hex_out}, 32'h40);
        bus_read(2'd3, rd); check("freeze_changed0", {31'h0, rd[1]}, 32'h0);
        bus_write(2'd0, 32'h1);
        exp_q.push_back(7'h79);
        repeat (2) @(negedge clk);
        sb_check("unfreeze_hex", hex_out);
        bus_read(2'd3, rd); check("unfreeze_changed1", {31'h0, rd[1]}, 32'h1);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rd); check("w1c_status", rd, 32'h0);

        // ---- 5: W1C in the same cycle as a pattern change: set wins ----
        @(negedge clk);
        address    = 2'd3;
        writedata  = 32'h2;
        chipselect = 1'b1;
        write_n    = 1'b0;
        seg_in     = 7'h5B;
        exp_q.push_back(7'h24);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        bus_read(2'd3, rd); check("w1c_vs_set", {31'h0, rd[1]}, 32'h1);
        @(negedge clk);
        sb_check("w1c_vs_set_hex", hex_out);

        // ---- 6: fade ----
        bus_write(2'd3, 32'h2);
        bus_write(2'd1, 32'h04);
        @(negedge clk);
        seg_in = 7'h06;
        repeat (2) @(negedge clk);
`ifdef HEX_DRV_FADE_EN
        bus_read(2'd3, rd); check("fading_set", {31'h0, rd[2]}, 32'h1);
        begin
            int waited;
            waited = 0;
            while (waited < 8 * 512) begin
                @(negedge clk);
                waited++;
                bus_read(2'd3, rd);
                if (rd[2] == 1'b0) break;
            end
            check("fade_done_in_window",
                  {31'h0, (waited >= 3 * 512) && (waited <= 6 * 512)}, 32'h1);
        end
`else
        bus_read(2'd3, rd); check("fading_reads0", {31'h0, rd[2]}, 32'h0);
`endif
        count_lit(7'h06, 512, lit, other);
        check("bright4_after_change", lit, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
